// File: rtl/wb_timer_pkg.sv
// Shared constants and types for the Wishbone timer: register offsets,
// CTRL bit positions and the CTRL register layout.
package wb_timer_pkg;

  localparam logic [5:0] OFF_CTRL     = 6'h00;
  localparam logic [5:0] OFF_PRESCALE = 6'h01;
  localparam logic [5:0] OFF_RELOAD   = 6'h02;
  localparam logic [5:0] OFF_COUNT    = 6'h03;
  localparam logic [5:0] OFF_STATUS   = 6'h04;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;

  // Field order puts en at bit 0 so the struct maps straight onto CTRL[2:0].
  typedef struct packed {
    logic irq_en;
    logic auto_reload;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/wb_timer_irq_core.sv
// Prescaler, 32-bit down-counter, sticky expiry flag and reload logic.
// Bus-side writes arrive as already-decoded single-cycle strobes.
module timer_core
  import wb_timer_pkg::*;
#(
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             en,
  input  logic             auto_reload,
  input  logic [PRE_W-1:0] prescale,
  input  logic [31:0]      reload,
  input  logic             prescale_wr,
  input  logic             count_wr,
  input  logic [31:0]      count_wr_data,
  input  logic             status_clr,
  output logic [31:0]      count,
  output logic             expired,
  output logic             hw_en_clr
);

  logic [PRE_W-1:0] pre_cnt_reg, pre_cnt_next;
  logic [31:0]      count_reg, count_next;
  logic             expired_reg, expired_next;
  logic             tick;

  assign tick = en && (pre_cnt_reg == prescale);

  always_comb begin
    pre_cnt_next = pre_cnt_reg;
    count_next   = count_reg;
    expired_next = expired_reg;
    hw_en_clr    = 1'b0;

    // Equality compare: a PRESCALE write restarts the prescaler so a new
    // value below the current count can never be skipped over.
    if (!en || prescale_wr || tick) begin
      pre_cnt_next = '0;
    end else begin
      pre_cnt_next = pre_cnt_reg + 1'b1;
    end

    // Clear first so a coincident expiry below overrides it.
    if (status_clr) begin
      expired_next = 1'b0;
    end

    // A firmware COUNT write consumes a coincident tick entirely.
    if (count_wr) begin
      count_next = count_wr_data;
    end else if (tick) begin
      if (count_reg != 32'd0) begin
        count_next = count_reg - 32'd1;
      end else begin
        expired_next = 1'b1;
        if (auto_reload) begin
          count_next = reload;
        end else begin
          hw_en_clr = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      pre_cnt_reg <= '0;
      count_reg   <= '0;
      expired_reg <= 1'b0;
    end else begin
      pre_cnt_reg <= pre_cnt_next;
      count_reg   <= count_next;
      expired_reg <= expired_next;
    end
  end

  assign count   = count_reg;
  assign expired = expired_reg;

endmodule

// File: rtl/wb_timer_irq.sv
// Wishbone slave front end for the timer: address decode, one-wait-state
// ack, byte-lane write merging, CTRL/PRESCALE/RELOAD storage and readback.
module wb_timer_irq
  import wb_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FF00,
  parameter int          PRE_W     = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [2:0]  irq
);

  logic             sel_hit;
  logic [5:0]       word_off;
  logic             wr_en;
  logic [31:0]      wr_mask;
  logic             ack_reg;
  logic [31:0]      dat_reg;
  logic [31:0]      rdata;
  ctrl_t            ctrl_reg, ctrl_next;
  logic [PRE_W-1:0] prescale_reg, prescale_next;
  logic [31:0]      reload_reg, reload_next;
  logic [31:0]      count;
  logic [31:0]      count_wr_data;
  logic             expired;
  logic             hw_en_clr;
  logic             wr_ctrl, wr_prescale, wr_reload, wr_count, status_clr;

  assign sel_hit  = wbs_cyc_i && wbs_stb_i && ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign word_off = wbs_adr_i[7:2];

  // Writes land on the clock edge that closes the ack cycle, once per ack.
  assign wr_en = ack_reg && sel_hit && wbs_we_i;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wr_mask[8*gi +: 8] = {8{wbs_sel_i[gi]}};
  end

  assign wr_ctrl     = wr_en && (word_off == OFF_CTRL);
  assign wr_prescale = wr_en && (word_off == OFF_PRESCALE);
  assign wr_reload   = wr_en && (word_off == OFF_RELOAD);
  assign wr_count    = wr_en && (word_off == OFF_COUNT);
  assign status_clr  = wr_en && (word_off == OFF_STATUS) && wbs_sel_i[0] && wbs_dat_i[0];

  assign count_wr_data = (count & ~wr_mask) | (wbs_dat_i & wr_mask);

  always_comb begin
    ctrl_next     = ctrl_reg;
    prescale_next = prescale_reg;
    reload_next   = reload_reg;
    // The bus write is applied after the one-shot clear so firmware wins.
    if (hw_en_clr) begin
      ctrl_next.en = 1'b0;
    end
    if (wr_ctrl && wbs_sel_i[0]) begin
      ctrl_next.en          = wbs_dat_i[CTRL_EN];
      ctrl_next.auto_reload = wbs_dat_i[CTRL_AUTO_RELOAD];
      ctrl_next.irq_en      = wbs_dat_i[CTRL_IRQ_EN];
    end
    if (wr_prescale) begin
      prescale_next = (prescale_reg & ~wr_mask[PRE_W-1:0]) |
                      (wbs_dat_i[PRE_W-1:0] & wr_mask[PRE_W-1:0]);
    end
    if (wr_reload) begin
      reload_next = (reload_reg & ~wr_mask) | (wbs_dat_i & wr_mask);
    end
  end

  always_comb begin
    rdata = '0;
    case (word_off)
      OFF_CTRL:     rdata = {29'd0, ctrl_reg};
      OFF_PRESCALE: rdata = 32'(prescale_reg);
      OFF_RELOAD:   rdata = reload_reg;
      OFF_COUNT:    rdata = count;
      OFF_STATUS:   rdata = {31'd0, expired};
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_reg      <= 1'b0;
      dat_reg      <= '0;
      ctrl_reg     <= '0;
      prescale_reg <= '0;
      reload_reg   <= '0;
    end else begin
      ack_reg      <= sel_hit && !ack_reg;
      dat_reg      <= (sel_hit && !ack_reg) ? rdata : 32'd0;
      ctrl_reg     <= ctrl_next;
      prescale_reg <= prescale_next;
      reload_reg   <= reload_next;
    end
  end

  timer_core #(
    .PRE_W(PRE_W)
  ) u_core (
    .clk           (wb_clk_i),
    .srst          (wb_rst_i),
    .en            (ctrl_reg.en),
    .auto_reload   (ctrl_reg.auto_reload),
    .prescale      (prescale_reg),
    .reload        (reload_reg),
    .prescale_wr   (wr_prescale),
    .count_wr      (wr_count),
    .count_wr_data (count_wr_data),
    .status_clr    (status_clr),
    .count         (count),
    .expired       (expired),
    .hw_en_clr     (hw_en_clr)
  );

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = dat_reg;
  assign irq       = {2'b00, expired && ctrl_reg.irq_en};

endmodule
